// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared types and constants for the writeback trace transmitter
// Frame length depends on macro WB_TRACE_PARITY_EN.
package wb_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int frame_bits(input int data_w);
`ifdef WB_TRACE_PARITY_EN
        return data_w + 3;
`else
        return data_w + 2;
`endif
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - synchronous DEPTH x DATA_W FIFO buffering writeback words
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/wb_trace_tx.sv
// rtl/wb_trace_tx.sv - serialises buffered busw writebacks onto a framed debug line
// Macro WB_TRACE_PARITY_EN adds an even-parity bit between data and stop.
module wb_trace_tx
    import wb_trace_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [DATA_W-1:0]          busw,
    output logic                       tx_serial,
    output logic                       tx_busy,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int CDW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW  = $clog2(frame_bits(DATA_W));
    localparam logic [CDW-1:0] CLK_LAST = CDW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CDW-1:0]    clk_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              tx_serial_q;
    logic              tx_busy_q;
    logic              overflow_q;
`ifdef WB_TRACE_PARITY_EN
    logic              parity_q;
`endif

    logic [DATA_W-1:0] head;
    logic              fifo_empty;
    logic              bit_end;
    logic              pop;
    logic              push;

    // A pop in the last stop-bit cycle chains the next start bit with no idle gap.
    assign bit_end = (clk_cnt_q == CLK_LAST);
    assign pop     = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
    assign push    = wb_valid && (!full || pop);

    wb_trace_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (busw),
        .rdata (head),
        .full  (full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            tx_serial_q <= STOP_BIT;
            tx_busy_q   <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef WB_TRACE_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            if (wb_valid && full && !pop) begin
                overflow_q <= 1'b1;
            end
            clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;

            if (pop) begin
                state_q     <= ST_START;
                shift_q     <= head;
                tx_serial_q <= START_BIT;
                tx_busy_q   <= 1'b1;
                clk_cnt_q   <= '0;
`ifdef WB_TRACE_PARITY_EN
                parity_q    <= ^head;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        clk_cnt_q <= '0;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            state_q     <= ST_DATA;
                            tx_serial_q <= shift_q[0];
                            bit_cnt_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            if (bit_cnt_q == BIT_LAST) begin
`ifdef WB_TRACE_PARITY_EN
                                state_q     <= ST_PARITY;
                                tx_serial_q <= parity_q;
`else
                                state_q     <= ST_STOP;
                                tx_serial_q <= STOP_BIT;
`endif
                            end else begin
                                shift_q     <= shift_q >> 1;
                                tx_serial_q <= shift_q[1];
                                bit_cnt_q   <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) begin
                            state_q     <= ST_STOP;
                            tx_serial_q <= STOP_BIT;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end) begin
                            state_q     <= ST_IDLE;
                            tx_serial_q <= STOP_BIT;
                            tx_busy_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        tx_serial_q <= STOP_BIT;
                        tx_busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = tx_busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_trace_tx.sv
// tb/tb_wb_trace_tx.sv - randomized scoreboard bench for wb_trace_tx with a line receiver
// Honours WB_TRACE_PARITY_EN for the frame layout.
module tb_wb_trace_tx;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int CPB    = 4;
`ifdef WB_TRACE_PARITY_EN
    localparam int FB = DATA_W + 3;
`else
    localparam int FB = DATA_W + 2;
`endif
    localparam int FC = FB * CPB;

    logic              clock = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic [DATA_W-1:0] busw;
    logic              tx_serial;
    logic              tx_busy;
    logic              full;
    logic [3:0]        count;
    logic              overflow;

    wb_trace_tx #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .busw      (busw),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    // Reference model: each accepted word gets an enqueue edge e and a pop edge p.
    int edge_cnt = 0;
    int acc_e[$];
    int acc_p[$];
    logic [DATA_W-1:0] exp_q[$];
    int last_p   = -100000;
    int ovf_edge = 32'h7fff_ffff;

    function automatic int model_count(input int c);
        int n = 0;
        foreach (acc_e[i]) if (acc_e[i] <= c && acc_p[i] > c) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int c);
        foreach (acc_p[i]) if (acc_p[i] <= c && c < acc_p[i] + FC) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        acc_e.delete();
        acc_p.delete();
        exp_q.delete();
        last_p   = -100000;
        ovf_edge = 32'h7fff_ffff;
    endfunction

    // Line receiver plus per-cycle status checks, sampled 2 time units after each edge.
    logic [FC-1:0] rx_buf;
    int rx_n = 0;
    int rx_frames = 0;
    int busy_samples = 0;

    task automatic decode_frame();
        logic [DATA_W-1:0] d;
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < FB; b++)
            for (int k = 1; k < CPB; k++)
                if (rx_buf[b*CPB+k] != rx_buf[b*CPB]) ok = 1'b0;
        for (int b = 0; b < DATA_W; b++) d[b] = rx_buf[(b+1)*CPB];
        if (rx_buf[0] != 1'b0 || rx_buf[(FB-1)*CPB] != 1'b1) ok = 1'b0;
`ifdef WB_TRACE_PARITY_EN
        if (rx_buf[(DATA_W+1)*CPB] != ^d) ok = 1'b0;
`endif
        check("frame_format", ok, 1);
        check("rx_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_data", d, exp_q.pop_front());
        rx_frames++;
    endtask

    always @(posedge clock) begin
        int c;
        edge_cnt = edge_cnt + 1;
        #2;
        c = edge_cnt;
        check("count", count, model_count(c));
        check("full", full, model_count(c) == DEPTH);
        check("overflow", overflow, ovf_edge <= c);
        check("tx_busy", tx_busy, model_busy(c));
        if (!model_busy(c)) check("idle_line", tx_serial, 1);
        if (tx_busy) busy_samples++;
        if (reset) begin
            rx_n = 0;
        end else if (rx_n == 0) begin
            if (tx_serial == 1'b0) begin
                rx_buf[0] = 1'b0;
                rx_n = 1;
            end
        end else begin
            rx_buf[rx_n] = tx_serial;
            rx_n++;
            if (rx_n == FC) begin
                decode_frame();
                rx_n = 0;
            end
        end
    end

    task automatic push(input logic [DATA_W-1:0] d);
        int e, n;
        @(negedge clock);
        e = edge_cnt + 1;
        n = 0;
        foreach (acc_e[i]) if (acc_e[i] < e && acc_p[i] > e) n++;
        if (n < DEPTH) begin
            last_p = (e + 1 > last_p + FC) ? e + 1 : last_p + FC;
            acc_e.push_back(e);
            acc_p.push_back(last_p);
            exp_q.push_back(d);
        end else if (ovf_edge > e) begin
            ovf_edge = e;
        end
        wb_valid = 1'b1;
        busw     = d;
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        wb_valid = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        wb_valid = 1'b1;
        busw     = $urandom;
        model_clear();
        @(negedge clock);
        reset    = 1'b0;
        wb_valid = 1'b0;
        check("rst_tx_serial", tx_serial, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
    endtask

    task automatic drain(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            if (exp_q.size() == 0 && !tx_busy && rx_n == 0) break;
            @(negedge clock);
        end
        check("drain_done", k < lim, 1);
    endtask

    initial begin
        int f0, b0, target;
        reset    = 1'b1;
        wb_valid = 1'b0;
        busw     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_tx_serial", tx_serial, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_count", count, 0);
        check("reset_full", full, 0);
        check("reset_overflow", overflow, 0);

        f0 = rx_frames; b0 = busy_samples;
        push(32'h0000_00A5); idle(1); drain(2000);
        check("single_frames", rx_frames - f0, 1);
        check("single_busy_cycles", busy_samples - b0, FC);

        f0 = rx_frames;
        push(32'hDEAD_BEEF); push(32'h1234_5678); idle(1); drain(3000);
        check("b2b_frames", rx_frames - f0, 2);

        f0 = rx_frames;
        for (int i = 0; i < 10; i++) push($urandom);
        idle(1);
        drain(5000);
        check("ovf_frames", rx_frames - f0, 9);
        check("ovf_sticky", overflow, 1);

        f0 = rx_frames;
        push($urandom); idle(1);
        target = last_p + 10 * CPB + 1;
        for (int k = 0; k < 1000 && edge_cnt < target; k++) @(negedge clock);
        check("midrst_reached", edge_cnt >= target, 1);
        do_reset();
        repeat (400) @(negedge clock);
        check("midrst_frames", rx_frames - f0, 0);

        f0 = rx_frames;
        for (int i = 0; i < 20; i++) begin
            push(i);
            if (i % 4 == 3) idle(1);
            else idle($urandom_range(150, 300));
        end
        drain(6000);
        check("wrap_frames", rx_frames - f0, 20);
        check("wrap_no_overflow", overflow, 0);

        for (int i = 0; i < 30; i++) begin
            push($urandom);
            idle($urandom_range(1, 160));
        end
        drain(8000);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
